pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports id_rs1, id_rs2  input  5 each  ID-stage source registers.
REQ-004 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-005 SHALL have port ex_rd  input  5  EX-stage destination register.
REQ-006 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-007 SHALL have port ex_redirect  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 SHALL have port imem_ready  input  1  instruction memory returns valid word this cycle.
REQ-009 SHALL have port dmem_busy  input  1  data memory stalls MEM stage.
REQ-010 SHALL have ports pc_en, if_id_en, if_id_flush, id_ex_flush  output  1 each  pipeline control.
REQ-011 SHALL have port stall_cnt  output  32  saturating count of stall cycles.
REQ-012 SHALL have port redirect_cnt  output  16  saturating count of redirects.

Function
REQ-013 SHALL define hazard = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-014 SHALL implement a state register with states RUN and DRAIN; control outputs are combinational from state and inputs.
REQ-015 Default (RUN, no event) SHALL drive pc_en=1, if_id_en=1, both flushes 0.
REQ-016 Priority 1, dmem_busy=1: pc_en=0, if_id_en=0, flushes 0; state unchanged; stall_cnt+1.
REQ-017 Priority 2, ex_redirect=1: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1; next state DRAIN if imem_ready=0, else RUN; redirect_cnt+1.
REQ-018 Priority 3, state DRAIN: pc_en=0, if_id_flush=1, id_ex_flush=0; on imem_ready=1, discard returned word, next state RUN; stall_cnt+1.
REQ-019 Priority 4, hazard=1: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0; stall_cnt+1.
REQ-020 Priority 5, imem_ready=0: pc_en=0, if_id_en=1, if_id_flush=1 (NOP bubble); stall_cnt+1.
REQ-021 Load-use stall SHALL last exactly one cycle for a single dependent instruction (EX advances to MEM and hazard clears).
REQ-022 ex_redirect in DRAIN SHALL re-apply REQ-017 (state stays DRAIN while imem_ready=0).
REQ-023 Counters SHALL saturate at all-ones, never wrap.
REQ-024 ex_rd=0 SHALL never raise hazard.

Reset
REQ-025 Reset SHALL force state RUN and stall_cnt=0, redirect_cnt=0 immediately, independent of clk.
REQ-026 During reset outputs SHALL be pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=0.
REQ-027 Reset asserted mid-DRAIN SHALL abandon the drain; first cycle after release is RUN.

Structure
REQ-028 State enum (RUN, DRAIN) and counter widths SHALL reside in shared package pipe_ctrl_pkg.
REQ-029 Register-compare logic SHALL be one sub-module hazard_cmp (pure combinational, outputs hazard).
REQ-030 Counter update logic SHALL be in pipe_hazard_ctrl; no other sub-modules.

Verification
REQ-031 Load x5, ID uses rs1=x5, ex_mem_read=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt 0->1.
REQ-032 ex_redirect=1, imem_ready=1 -> if_id_flush=1, id_ex_flush=1, pc_en=1; next state RUN; redirect_cnt=1.
REQ-033 ex_redirect=1, imem_ready=0 for 3 cycles then 1 -> DRAIN 3 cycles with if_id_flush=1, pc_en=0; RUN after the ready beat; stall_cnt=3.
REQ-034 dmem_busy=1 with hazard=1 and ex_redirect=1 simultaneously -> freeze only (pc_en=0, if_id_en=0, flushes 0), redirect_cnt unchanged.
REQ-035 Load with ex_rd=0 and matching id_rs1=0 -> no stall, pc_en=1.
REQ-036 Preload stall_cnt near 0xFFFFFFFF via forced stalls -> holds 0xFFFFFFFF; reset mid-DRAIN -> state RUN, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned STALL_CNT_W = 32;
  localparam int unsigned REDIR_CNT_W = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detect: EX load writes a register the ID instruction reads.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  output logic             hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load to it never creates a dependency
  assign hazard    = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with redirect drain and saturating event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       id_rs1,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_W-1:0]       ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_redirect,
  input  logic                   imem_ready,
  input  logic                   dmem_busy,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [REDIR_CNT_W-1:0] redirect_cnt
);

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [REDIR_CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic                   hazard;
  logic                   stall_inc;
  logic                   redir_inc;

  hazard_cmp u_hazard_cmp (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (hazard)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Prioritised control: memory freeze > redirect > drain > load-use > fetch bubble
  always_comb begin
    state_d     = state_q;
    stall_inc   = 1'b0;
    redir_inc   = 1'b0;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (dmem_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      stall_inc = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redir_inc   = 1'b1;
      state_d     = imem_ready ? ST_RUN : ST_DRAIN;
    end else if (state_q == ST_DRAIN) begin
      // the stale wrong-path fetch is dropped when it finally returns
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      stall_inc   = 1'b1;
      if (imem_ready) state_d = ST_RUN;
    end else if (hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc   = 1'b1;
    end else if (!imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      stall_inc   = 1'b1;
    end
    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall_inc && !(&stall_cnt_q))    stall_cnt_d    = stall_cnt_q + STALL_CNT_W'(1);
    if (redir_inc && !(&redirect_cnt_q)) redirect_cnt_d = redirect_cnt_q + REDIR_CNT_W'(1);
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed check of pipe_hazard_ctrl against a priority-rule model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_mem_read, ex_redirect, imem_ready, dmem_busy;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic [31:0] stall_cnt;
  logic [15:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  bit          m_drain;
  longint unsigned m_stall, m_redir;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .imem_ready   (imem_ready),
    .dmem_busy    (dmem_busy),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected behaviour from the priority rules, compared then advanced one clock
  task automatic model_cycle();
    bit e_pc, e_en, e_iff, e_ief, haz, inc_s, inc_r, nxt;
    e_pc = 1; e_en = 1; e_iff = 0; e_ief = 0; inc_s = 0; inc_r = 0; nxt = m_drain;
    if (reset) begin
      e_pc = 0; e_en = 0;
      m_drain = 0; m_stall = 0; m_redir = 0; nxt = 0;
    end else begin
      haz = ex_mem_read && (ex_rd != 0) &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (dmem_busy) begin
        e_pc = 0; e_en = 0; inc_s = 1;
      end else if (ex_redirect) begin
        e_iff = 1; e_ief = 1; inc_r = 1; nxt = !imem_ready;
      end else if (m_drain) begin
        e_pc = 0; e_iff = 1; inc_s = 1;
        if (imem_ready) nxt = 0;
      end else if (haz) begin
        e_pc = 0; e_en = 0; e_ief = 1; inc_s = 1;
      end else if (!imem_ready) begin
        e_pc = 0; e_iff = 1; inc_s = 1;
      end
    end
    chk("pc_en",        32'(pc_en),        32'(e_pc));
    chk("if_id_en",     32'(if_id_en),     32'(e_en));
    chk("if_id_flush",  32'(if_id_flush),  32'(e_iff));
    chk("id_ex_flush",  32'(id_ex_flush),  32'(e_ief));
    chk("stall_cnt",    stall_cnt,         32'(m_stall));
    chk("redirect_cnt", 32'(redirect_cnt), 32'(m_redir));
    m_drain = nxt;
    if (inc_s && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (inc_r && m_redir < 64'hFFFF) m_redir++;
  endtask

  task automatic step(input bit rst, input bit busy, input bit redir, input bit imr,
                      input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit u1, input bit u2);
    @(negedge clk);
    reset = rst; dmem_busy = busy; ex_redirect = redir; imem_ready = imr;
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    #1;
    model_cycle();
  endtask

  task automatic idle();
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; dmem_busy = 0; ex_redirect = 0; imem_ready = 1; ex_mem_read = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    m_drain = 0; m_stall = 0; m_redir = 0;

    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    idle();
    chk("run_pc_en", 32'(pc_en), 32'd1);

    // load x5, ID reads x5
    step(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_id_en", 32'(if_id_en), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    idle();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    chk("lu_released", 32'(pc_en), 32'd1);

    // redirect with fetch ready
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("rd_flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    chk("rd_pc_en", 32'(pc_en), 32'd1);
    idle();
    chk("rd_cnt", 32'(redirect_cnt), 32'd1);
    chk("rd_run", 32'(pc_en), 32'd1);

    // redirect with fetch miss: three drain cycles
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("dr_pc_en", 32'(pc_en), 32'd0);
      chk("dr_if_id_flush", 32'(if_id_flush), 32'd1);
    end
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("dr_last_pc_en", 32'(pc_en), 32'd0);
    idle();
    chk("dr_run_pc_en", 32'(pc_en), 32'd1);
    chk("dr_stall_cnt", stall_cnt, 32'd4);
    chk("dr_redir_cnt", 32'(redirect_cnt), 32'd2);

    // busy + hazard + redirect together: freeze only
    step(0, 1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    chk("fz_outs", {28'd0, pc_en, if_id_en, if_id_flush, id_ex_flush}, 32'd0);
    idle();
    chk("fz_redir_cnt", 32'(redirect_cnt), 32'd2);
    chk("fz_stall_cnt", stall_cnt, 32'd5);

    // load to x0 never stalls
    step(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0);
    chk("x0_pc_en", 32'(pc_en), 32'd1);
    chk("x0_id_ex_flush", 32'(id_ex_flush), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) > 2), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // redirect counter saturation
    for (int i = 0; i < 65540; i++) step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("redir_sat", 32'(redirect_cnt), 32'h0000_FFFF);

    // stall counter preloaded just below saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_stall = 64'hFFFF_FFFD;
    repeat (5) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("stall_sat", stall_cnt, 32'hFFFF_FFFF);

    // reset in the middle of a drain
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_drain", 32'(pc_en), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_outs", {28'd0, pc_en, if_id_en, if_id_flush, id_ex_flush}, 32'd0);
    chk("mid_rst_stall", stall_cnt, 32'd0);
    chk("mid_rst_redir", 32'(redirect_cnt), 32'd0);
    idle();
    chk("post_rst_run", 32'(pc_en), 32'd1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
